// File: rtl/hazard_scoreboard_pkg.sv
// Shared op-class encoding and producer-latency lookup for the hazard scoreboard.
// Optional feature macro used elsewhere in the block: HAZ_PERF_CNT_EN.
package hazard_pkg;

  typedef enum logic [1:0] {
    OP_ALU  = 2'd0,
    OP_LOAD = 2'd1,
    OP_MUL  = 2'd2,
    OP_RSV  = 2'd3
  } op_e;

  // Cycles a producer needs before its result can be forwarded; the reserved code behaves as ALU.
  function automatic int unsigned lat(input logic [1:0] op, input int unsigned mul_lat);
    case (op)
      OP_ALU:  lat = 32'd1;
      OP_LOAD: lat = 32'd2;
      OP_MUL:  lat = mul_lat;
      default: lat = 32'd1;
    endcase
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID/EX pipeline-control bundle between the decode stage (master) and the scoreboard (slave).
// Optional feature macro used elsewhere in the block: HAZ_PERF_CNT_EN.
interface hazard_scoreboard_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned DEPTH  = 3
);
  localparam int unsigned FW_W = $clog2(DEPTH + 1);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [1:0]        id_rs_used;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic [1:0]        id_op;
  logic              ex_flush;
  logic              stall;
  logic              ex_valid;
  logic [FW_W-1:0]   ex_fw1;
  logic [FW_W-1:0]   ex_fw2;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs_used, id_rd, id_reg_write, id_op, ex_flush,
    input  stall, ex_valid, ex_fw1, ex_fw2
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs_used, id_rd, id_reg_write, id_op, ex_flush,
    output stall, ex_valid, ex_fw1, ex_fw2
  );
endinterface

// File: rtl/hazard_scoreboard_src_match.sv
// One source operand compared against every in-flight producer: forwarding select and stall need.
// Optional feature macro used elsewhere in the block: HAZ_PERF_CNT_EN.
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned DEPTH   = 3,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned FW_W    = 2
) (
  input  logic [REG_AW-1:0]            i_rs,
  input  logic                         i_used,
  input  logic [DEPTH-1:0]             i_vld,
  input  logic [DEPTH-1:0][REG_AW-1:0] i_rd,
  input  logic [DEPTH-1:0][1:0]        i_op,
  output logic [FW_W-1:0]              o_sel,
  output logic                         o_need_stall
);

  logic [FW_W-1:0] w_sel;
  logic            w_need;
  logic            w_hit;
  logic            w_ok;
  logic            w_active;

  // Walk oldest to youngest so the lowest matching entry (youngest producer) is the last to win.
  always_comb begin
    w_sel  = '0;
    w_need = 1'b0;
    w_hit  = 1'b0;
    w_ok   = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      w_hit  = i_vld[k] && (i_rd[k] == i_rs);
      w_ok   = ($unsigned(k) + 32'd1) >= lat(i_op[k], MUL_LAT);
      w_sel  = w_hit ? (w_ok ? FW_W'(k + 1) : '0) : w_sel;
      w_need = w_hit ? !w_ok : w_need;
    end
  end

  assign w_active     = i_used && (i_rs != '0);
  assign o_sel        = w_active ? w_sel : '0;
  assign o_need_stall = w_active & w_need;

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard: tracks in-flight producers, picks forwarding sources, stalls ID when too early.
// Define HAZ_PERF_CNT_EN to add the saturating stall_cnt performance counter output.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DEPTH   = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_scoreboard_if.slave  bus
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]         stall_cnt
`endif
);

  localparam int unsigned FW_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]             r_vld;
  logic [DEPTH-1:0][REG_AW-1:0] r_rd;
  logic [DEPTH-1:0][1:0]        r_op;

  logic [FW_W-1:0] w_sel1;
  logic [FW_W-1:0] w_sel2;
  logic            w_need1;
  logic            w_need2;
  logic            w_stall;
  logic            w_adv;
  logic            w_track;

  hazard_src_match #(
    .REG_AW (REG_AW),
    .DEPTH  (DEPTH),
    .MUL_LAT(MUL_LAT),
    .FW_W   (FW_W)
  ) u_match_rs1 (
    .i_rs        (bus.id_rs1),
    .i_used      (bus.id_rs_used[0]),
    .i_vld       (r_vld),
    .i_rd        (r_rd),
    .i_op        (r_op),
    .o_sel       (w_sel1),
    .o_need_stall(w_need1)
  );

  hazard_src_match #(
    .REG_AW (REG_AW),
    .DEPTH  (DEPTH),
    .MUL_LAT(MUL_LAT),
    .FW_W   (FW_W)
  ) u_match_rs2 (
    .i_rs        (bus.id_rs2),
    .i_used      (bus.id_rs_used[1]),
    .i_vld       (r_vld),
    .i_rd        (r_rd),
    .i_op        (r_op),
    .o_sel       (w_sel2),
    .o_need_stall(w_need2)
  );

  // A flushed ID instruction never stalls; flush outranks the hazard.
  assign w_stall   = bus.id_valid & ~bus.ex_flush & (w_need1 | w_need2);
  assign w_adv     = ~w_stall & ~bus.ex_flush;
  assign w_track   = w_adv & bus.id_valid & bus.id_reg_write & (bus.id_rd != '0);
  assign bus.stall = w_stall;

  // Producer shift register plus EX-stage valid/select registers; stalls and flushes inject bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld        <= '0;
      r_rd         <= '0;
      r_op         <= '0;
      bus.ex_valid <= 1'b0;
      bus.ex_fw1   <= '0;
      bus.ex_fw2   <= '0;
    end else begin
      r_vld        <= {r_vld[DEPTH-2:0], w_track};
      r_rd         <= {r_rd[DEPTH-2:0], bus.id_rd};
      r_op         <= {r_op[DEPTH-2:0], bus.id_op};
      bus.ex_valid <= w_adv & bus.id_valid;
      bus.ex_fw1   <= w_adv ? w_sel1 : '0;
      bus.ex_fw2   <= w_adv ? w_sel2 : '0;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= 32'd0;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed table-driven bench for hazard_scoreboard (REG_AW=5, MUL_LAT=3, DEPTH=3).
// Also exercises stall_cnt when HAZ_PERF_CNT_EN is defined.
module tb_hazard_scoreboard;

  logic clk;
  logic rst_n;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  hazard_scoreboard_if #(.REG_AW(5), .DEPTH(3)) bus ();

  hazard_scoreboard #(.REG_AW(5), .MUL_LAT(3), .DEPTH(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [1:0] used;
    logic [4:0] rd;
    logic       rw;
    logic [1:0] op;
    logic       fl;
    logic       exp_stall;
    logic       exp_exv;
    logic [1:0] exp_fw1;
    logic [1:0] exp_fw2;
  } vec_t;

  vec_t tv[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic r, input logic v, input int rs1, input int rs2, input int used,
                     input int rd, input logic rw, input int op, input logic fl,
                     input logic st, input logic exv, input int fw1, input int fw2);
    vec_t t;
    t.rst_n = r;  t.v = v;  t.rs1 = 5'(rs1);  t.rs2 = 5'(rs2);  t.used = 2'(used);
    t.rd = 5'(rd);  t.rw = rw;  t.op = 2'(op);  t.fl = fl;
    t.exp_stall = st;  t.exp_exv = exv;  t.exp_fw1 = 2'(fw1);  t.exp_fw2 = 2'(fw2);
    tv.push_back(t);
  endtask

  task automatic drive(input logic r, input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [1:0] used, input logic [4:0] rd, input logic rw,
                       input logic [1:0] op, input logic fl);
    rst_n            = r;
    bus.id_valid     = v;
    bus.id_rs1       = rs1;
    bus.id_rs2       = rs2;
    bus.id_rs_used   = used;
    bus.id_rd        = rd;
    bus.id_reg_write = rw;
    bus.id_op        = op;
    bus.ex_flush     = fl;
  endtask

  task automatic chk(input string name, input int row, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
    end
  endtask

  initial begin
    int n_st;
    int cyc;
    clk = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0);

    //   rst v  rs1 rs2 used rd rw op fl | stall exv fw1 fw2
    add(0, 0, 0,  0,  0,  0,  0, 0, 0,   0, 0, 0, 0); // 0 reset
    add(1, 1, 5,  6,  3,  0,  0, 0, 0,   0, 1, 0, 0); // 1 first cycle after reset
    add(1, 1, 0,  0,  0,  5,  1, 0, 0,   0, 1, 0, 0); // 2 ALU r5
    add(1, 1, 5,  0,  1, 10,  0, 0, 0,   0, 1, 1, 0); // 3 read r5 -> fw1=1
    add(1, 1, 0,  0,  0,  7,  1, 1, 0,   0, 1, 0, 0); // 4 LOAD r7
    add(1, 1, 0,  7,  2,  0,  0, 0, 0,   1, 0, 0, 0); // 5 read r7 -> stall
    add(1, 1, 0,  7,  2,  0,  0, 0, 0,   0, 1, 0, 2); // 6 -> fw2=2
    add(1, 1, 0,  0,  0,  3,  1, 2, 0,   0, 1, 0, 0); // 7 MUL r3
    add(1, 1, 3,  0,  1,  0,  0, 0, 0,   1, 0, 0, 0); // 8 stall
    add(1, 1, 3,  0,  1,  0,  0, 0, 0,   1, 0, 0, 0); // 9 stall
    add(1, 1, 3,  0,  1,  0,  0, 0, 0,   0, 1, 3, 0); // 10 -> fw1=3
    add(1, 1, 0,  0,  0,  4,  1, 0, 0,   0, 1, 0, 0); // 11 ALU r4
    add(1, 1, 0,  0,  0,  4,  1, 0, 0,   0, 1, 0, 0); // 12 ALU r4
    add(1, 1, 4,  0,  1,  0,  0, 0, 0,   0, 1, 1, 0); // 13 youngest wins
    add(1, 1, 0,  0,  0,  9,  1, 1, 0,   0, 1, 0, 0); // 14 LOAD r9
    add(1, 1, 9,  0,  1, 11,  1, 1, 1,   0, 0, 0, 0); // 15 flushed reader (writes r11)
    add(1, 1, 11, 9,  3,  0,  0, 0, 0,   0, 1, 0, 2); // 16 r11 untracked, r9 at k=1
    add(1, 1, 0,  0,  0,  0,  1, 0, 0,   0, 1, 0, 0); // 17 ALU r0
    add(1, 1, 0,  0,  3,  0,  0, 0, 0,   0, 1, 0, 0); // 18 read r0
    add(1, 1, 0,  0,  0,  8,  1, 2, 0,   0, 1, 0, 0); // 19 MUL r8
    add(1, 1, 0,  8,  2,  0,  0, 0, 0,   1, 0, 0, 0); // 20 stall
    add(0, 1, 0,  8,  2,  0,  0, 0, 0,   1, 0, 0, 0); // 21 reset mid-stall
    add(1, 1, 0,  8,  2,  0,  0, 0, 0,   0, 1, 0, 0); // 22 producer discarded
    add(1, 1, 8,  0,  1,  0,  0, 0, 0,   0, 1, 0, 0); // 23
    add(1, 1, 0,  0,  0,  2,  1, 2, 0,   0, 1, 0, 0); // 24 MUL r2
    add(1, 1, 2,  0,  2,  0,  0, 0, 0,   0, 1, 0, 0); // 25 rs1 not used
    add(1, 0, 0,  0,  0,  0,  0, 0, 0,   0, 0, 0, 0); // 26 idle
    add(1, 1, 2,  0,  1,  0,  0, 0, 0,   0, 1, 3, 0); // 27 MUL at k=2 -> fw1=3
    add(1, 1, 0,  0,  0,  6,  1, 3, 0,   0, 1, 0, 0); // 28 op=3 acts as ALU
    add(1, 1, 6,  6,  3,  0,  0, 0, 0,   0, 1, 1, 1); // 29 both sources fw=1

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      drive(tv[i].rst_n, tv[i].v, tv[i].rs1, tv[i].rs2, tv[i].used,
            tv[i].rd, tv[i].rw, tv[i].op, tv[i].fl);
      #1;
      chk("stall", i, bus.stall, tv[i].exp_stall);
      @(posedge clk);
      #1;
      chk("ex_valid", i, bus.ex_valid, tv[i].exp_exv);
      chk("ex_fw1", i, bus.ex_fw1, tv[i].exp_fw1);
      chk("ex_fw2", i, bus.ex_fw2, tv[i].exp_fw2);
    end

    // Fresh reset, then a MUL consumer held until the stall releases (bounded).
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd0, 5'd0, 2'd0, 5'd3, 1'b1, 2'd2, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd3, 5'd0, 2'd1, 5'd0, 1'b0, 2'd0, 1'b0);
    n_st = 0;
    cyc  = 0;
    #1;
    while (bus.stall && cyc < 8) begin
      n_st++;
      cyc++;
      @(negedge clk);
      #1;
    end
    chk("mul_stall_bound", 100, cyc < 8, 1);
    chk("mul_stall_cycles", 100, n_st, 2);
    @(posedge clk);
    #1;
    chk("mul_ex_valid", 100, bus.ex_valid, 1);
    chk("mul_ex_fw1", 100, bus.ex_fw1, 3);
`ifdef HAZ_PERF_CNT_EN
    chk("stall_cnt", 100, stall_cnt, 2);
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    chk("stall_cnt_reset", 101, stall_cnt, 0);
`endif

    @(negedge clk);
    drive(1'b1, 1'b0, 5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    chk("idle_ex_valid", 102, bus.ex_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
